sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of requester ports, legal range 1..4.
REQ-002 SHALL have parameter ADDR_WIDTH, default 21: SRAM address width, legal range 19..21 (512KB..2MB).
REQ-003 SHALL have parameter WAIT_STATES, default 1: extra ACCESS cycles, legal range 0..7.
REQ-004 SHALL have port clk_chipset, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ch_req, input, CHANNELS bits: per-channel access request, level.
REQ-007 SHALL have port ch_we, input, CHANNELS bits: per-channel direction, 1=write, 0=read.
REQ-008 SHALL have port ch_addr, input, CHANNELS*ADDR_WIDTH bits: packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port ch_wdata, input, CHANNELS*8 bits: packed write data, channel i at [i*8 +: 8].
REQ-010 SHALL have port ch_ack, output, CHANNELS bits: one-hot, single-cycle completion pulse.
REQ-011 SHALL have port ch_rdata, output, 8 bits: read data shared by all channels, valid in the ack cycle.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port sram_addr, output, ADDR_WIDTH bits: SRAM address bus.
REQ-014 SHALL have port sram_data, inout, 8 bits: SRAM data bus, driven only during write cycles.
REQ-015 SHALL have port sram_we_n, output, 1 bit: SRAM write enable, active low; the SRAM output enable is tied active externally.

Function
REQ-016 SHALL implement the FSM IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_STATES+1 cycles) -> DONE (1 cycle) -> IDLE.
REQ-017 In IDLE with any ch_req bit high, the block SHALL grant one channel and latch its addr, we and wdata on that edge; later changes to these inputs SHALL have no effect on the access in progress.
REQ-018 Arbitration SHALL be round-robin: the search starts at (last granted + 1) mod CHANNELS, and the pointer is 0 after reset.
REQ-019 sram_addr SHALL present the latched address from SETUP through DONE and SHALL hold its last value while in IDLE.
REQ-020 Write: sram_data SHALL be driven with the latched wdata in SETUP, ACCESS and DONE; sram_we_n SHALL be low only in ACCESS; otherwise sram_data SHALL be high-Z.
REQ-021 Read: sram_we_n SHALL stay high; sram_data SHALL be sampled on the final ACCESS edge into ch_rdata.
REQ-022 ch_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-023 The ack bit of the granted channel SHALL be high for exactly the DONE cycle, i.e. the cycle starting WAIT_STATES+2 edges after the grant edge.
REQ-024 A requester SHALL keep ch_req high until its ack; a request still high in IDLE after an ack SHALL be treated as a new request, giving a minimum request period of WAIT_STATES+4 cycles.
REQ-025 Simultaneous requests SHALL be served one per transaction, in round-robin order; requests arriving outside IDLE SHALL wait and SHALL never be lost while held.
REQ-026 With CHANNELS=1, arbitration SHALL degenerate to a fixed grant of channel 0.

Reset
REQ-027 Reset SHALL force: state=IDLE, sram_we_n=1, sram_data=Z, sram_addr=0, ch_ack=0, ch_rdata=0x00, busy=0, RR pointer=0.
REQ-028 Reset asserted mid-access SHALL abort the access on the next edge: no ack is issued and sram_we_n=1 immediately; the aborted request SHALL be re-arbitrated only if still held after reset is released.

Verification
REQ-029 Defaults: ch0 writes 0x1FFFFF/0xA5 -> sram_we_n low exactly 2 cycles, data driven for 4 cycles, ch_ack[0] high 3 edges after the grant, busy high for 4 cycles.
REQ-030 Defaults: ch1 reads 0x1FFFFF with the SRAM model returning 0xA5 -> ch_rdata=0xA5 in the ch_ack[1] cycle, sram_we_n stays 1, sram_data undriven.
REQ-031 After reset, ch0 and ch1 request together and both hold req -> acks alternate ch0, ch1, ch0, ch1, with a period of 5 cycles per ack.
REQ-032 Reset asserted in the first ACCESS cycle of a write -> the next cycle shows sram_we_n=1, sram_data=Z, busy=0, and no ack.
REQ-033 CHANNELS=3, ADDR_WIDTH=19, WAIT_STATES=0, all three request continuously -> grant order 0,1,2,0; sram_addr is 19 bits; ack period is 4 cycles.
REQ-034 A channel changes ch_addr and ch_wdata one cycle after its grant -> the SRAM sees the originally latched values.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter giving up to four requesters
// access to one asynchronous 8-bit SRAM. Each transaction runs
// IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) -> DONE -> IDLE.
module sram_port_arbiter #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_WIDTH  = 21,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clk_chipset,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            ch_req,
  input  logic [CHANNELS-1:0]            ch_we,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr,
  input  logic [CHANNELS*8-1:0]          ch_wdata,
  output logic [CHANNELS-1:0]            ch_ack,
  output logic [7:0]                     ch_rdata,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  inout  wire  [7:0]                     sram_data,
  output logic                           sram_we_n
);

  // Channel indices are always 2 bits wide; per-channel inputs are padded
  // out to four slots so a 2-bit index selects them cleanly at any CHANNELS.
  localparam int IDX_W = 2;
  localparam int SLOTS = 4;
  localparam logic [2:0]       WS_LAST  = 3'(WAIT_STATES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [IDX_W-1:0]       grant_reg, grant_next;
  logic [2:0]             wait_cnt_reg, wait_cnt_next;
  logic                   we_reg, we_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [7:0]             wdata_reg, wdata_next;
  logic [7:0]             rdata_reg, rdata_next;

  logic [SLOTS-1:0]       req_pad;
  logic [SLOTS-1:0]       we_pad;
  logic [ADDR_WIDTH-1:0]  addr_arr  [SLOTS];
  logic [7:0]             wdata_arr [SLOTS];

  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       scan_idx;
  logic [SLOTS-1:0]       ack_pad;
  logic                   drive_en;

  assign req_pad = SLOTS'(ch_req);
  assign we_pad  = SLOTS'(ch_we);

  // Unpack the flat address/data buses; unused slots read as zero.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
    if (gi < CHANNELS) begin : g_used
      assign addr_arr[gi]  = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = ch_wdata[gi*8 +: 8];
    end else begin : g_unused
      assign addr_arr[gi]  = '0;
      assign wdata_arr[gi] = '0;
    end
  end

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_reg;
    scan_idx = ptr_reg;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && req_pad[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  // Next-state logic: grant and latch in IDLE, count wait states in ACCESS,
  // capture read data on the edge that leaves ACCESS.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    wait_cnt_next = wait_cnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = SETUP;
          grant_next = pick;
          ptr_next   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
          we_next    = we_pad[pick];
          addr_next  = addr_arr[pick];
          wdata_next = wdata_arr[pick];
        end
      end
      SETUP: begin
        state_next    = ACCESS;
        wait_cnt_next = '0;
      end
      ACCESS: begin
        if (wait_cnt_reg == WS_LAST) begin
          state_next = DONE;
          if (!we_reg) begin
            rdata_next = sram_data;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      wait_cnt_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      wait_cnt_reg <= wait_cnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
    end
  end

  // Outputs decode directly from registered state, so reset takes effect
  // on the SRAM strobes in the very next cycle.
  always_comb begin
    ack_pad = '0;
    if (state_reg == DONE) begin
      ack_pad[grant_reg] = 1'b1;
    end
  end

  assign ch_ack    = CHANNELS'(ack_pad);
  assign busy      = (state_reg != IDLE);
  assign sram_we_n = !((state_reg == ACCESS) && we_reg);
  assign drive_en  = we_reg && (state_reg != IDLE);
  assign sram_data = drive_en ? wdata_reg : 8'hzz;
  assign sram_addr = addr_reg;
  assign ch_rdata  = rdata_reg;

endmodule
